// File: rtl/moonbase_bus_responder.sv
// moonbase_bus_responder: nibble-serial code/data memory and device-write FIFO behind an 8-bit CPU io bus
module moonbase_bus_responder #(
    parameter int BYTES_PER_SPACE = 128,
    parameter int DW_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] bus_out,
    output logic [3:0] rd_nibble,
    output logic [1:0] rd_dev,
    input  logic [1:0] dev_in,
    input  logic       ld_valid,
    input  logic       ld_space,
    input  logic [6:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic       ld_ready,
    output logic       dw_valid,
    output logic [6:0] dw_addr,
    output logic [7:0] dw_data,
    input  logic       dw_ready,
    output logic       dw_overflow
);
    localparam int PW = $clog2(DW_FIFO_DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;
    state_t state, state_nx;
    logic [7:0] mem [2*BYTES_PER_SPACE];
    logic [6:0] latch;
    logic [3:0] hold;
    logic hold_valid;
    logic [6:0] fifo_addr [DW_FIFO_DEPTH];
    logic [7:0] fifo_data [DW_FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic [1:0] sync1, sync2;
    logic strobe, in_hl, ram_wr, dev_wr, push, pop, full, push_ok;
    logic [7:0] bus_idx, ld_idx;
    assign strobe = bus_out[7];
    assign in_hl = state == HI || state == LO;
    assign ram_wr = !strobe && !bus_out[5] && in_hl;
    assign dev_wr = !strobe && !bus_out[4];
    assign push = dev_wr && state == LO && hold_valid;
    assign pop = dw_valid && dw_ready;
    assign full = count == CW'(DW_FIFO_DEPTH);
    assign push_ok = push && (!full || pop);
    assign bus_idx = {bus_out[6], latch};
    assign ld_idx = {ld_space, ld_addr};
    assign ld_ready = !ram_wr;
    assign dw_valid = count != '0;
    assign dw_addr = fifo_addr[rp];
    assign dw_data = fifo_data[rp];
    assign rd_dev = sync2;
    assign rd_nibble = state == HI ? mem[bus_idx][7:4] : state == LO ? mem[bus_idx][3:0] : 4'h0;
    always_comb begin
        state_nx = strobe ? HI : state == HI ? LO : state == IDLE ? IDLE : DONE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            latch <= '0;
            hold <= '0;
            hold_valid <= 1'b0;
            wp <= '0;
            rp <= '0;
            count <= '0;
            dw_overflow <= 1'b0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            state <= state_nx;
            sync1 <= dev_in;
            sync2 <= sync1;
            if (strobe) latch <= bus_out[6:0];
            if (strobe) hold_valid <= 1'b0;
            else if (dev_wr && state == HI) begin
                hold <= bus_out[3:0];
                hold_valid <= 1'b1;
            end else if (push) hold_valid <= 1'b0;
            if (push_ok) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
            if (push && full && !pop) dw_overflow <= 1'b1;
        end
    end
    // Storage arrays survive reset; the bus write path is gated off in reset because state is IDLE.
    always_ff @(posedge clk) begin
        if (ram_wr) mem[bus_idx] <= state == HI ? {bus_out[3:0], mem[bus_idx][3:0]} : {mem[bus_idx][7:4], bus_out[3:0]};
        else if (ld_valid) mem[ld_idx] <= ld_data;
        if (push_ok) begin
            fifo_addr[wp] <= latch;
            fifo_data[wp] <= {hold, bus_out[3:0]};
        end
    end
endmodule

// File: tb/tb_moonbase_bus_responder.sv
// tb_moonbase_bus_responder: vector table plus directed sequences for the bus responder
module tb_moonbase_bus_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] bus_out = 8'h70;
    logic [3:0] rd_nibble;
    logic [1:0] rd_dev;
    logic [1:0] dev_in = 2'b00;
    logic ld_valid = 1'b0;
    logic ld_space = 1'b0;
    logic [6:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic ld_ready;
    logic dw_valid;
    logic [6:0] dw_addr;
    logic [7:0] dw_data;
    logic dw_ready = 1'b1;
    logic dw_overflow;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [7:0] bus;
        logic ldv;
        logic lsp;
        logic [6:0] lad;
        logic [7:0] ldd;
        logic [3:0] nib;
        logic ldr;
        logic dwv;
        logic [6:0] dwa;
        logic [7:0] dwd;
    } vec_t;
    vec_t v [24];
    always #5 clk = ~clk;
    moonbase_bus_responder dut (
        .clk(clk), .reset_n(reset_n), .bus_out(bus_out), .rd_nibble(rd_nibble), .rd_dev(rd_dev),
        .dev_in(dev_in), .ld_valid(ld_valid), .ld_space(ld_space), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .dw_valid(dw_valid), .dw_addr(dw_addr), .dw_data(dw_data),
        .dw_ready(dw_ready), .dw_overflow(dw_overflow)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic step(input logic [7:0] b);
        bus_out = b;
        tick();
    endtask
    task automatic dev_write(input logic [7:0] d, input logic pop_on_push);
        step(8'h85);
        step({4'h2, d[7:4]});
        dw_ready = pop_on_push;
        step({4'h2, d[3:0]});
        dw_ready = 1'b0;
    endtask
    initial begin
        v[0]  = '{8'h70, 1'b1, 1'b0, 7'h11, 8'h00, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[1]  = '{8'h70, 1'b1, 1'b0, 7'h05, 8'h96, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[2]  = '{8'h70, 1'b1, 1'b1, 7'h03, 8'h5A, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[3]  = '{8'h83, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[4]  = '{8'h7F, 1'b0, 1'b0, 7'h00, 8'h00, 4'h5, 1'b1, 1'b0, 7'h00, 8'h00};
        v[5]  = '{8'h7F, 1'b0, 1'b0, 7'h00, 8'h00, 4'hA, 1'b1, 1'b0, 7'h00, 8'h00};
        v[6]  = '{8'h7F, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[7]  = '{8'h91, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[8]  = '{8'h1C, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b0, 1'b0, 7'h00, 8'h00};
        v[9]  = '{8'h13, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b0, 1'b0, 7'h00, 8'h00};
        v[10] = '{8'h91, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[11] = '{8'h30, 1'b0, 1'b0, 7'h00, 8'h00, 4'hC, 1'b1, 1'b0, 7'h00, 8'h00};
        v[12] = '{8'h30, 1'b0, 1'b0, 7'h00, 8'h00, 4'h3, 1'b1, 1'b0, 7'h00, 8'h00};
        v[13] = '{8'h85, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[14] = '{8'h2A, 1'b0, 1'b0, 7'h00, 8'h00, 4'h9, 1'b1, 1'b0, 7'h00, 8'h00};
        v[15] = '{8'h27, 1'b0, 1'b0, 7'h00, 8'h00, 4'h6, 1'b1, 1'b0, 7'h00, 8'h00};
        v[16] = '{8'h70, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b1, 7'h05, 8'hA7};
        v[17] = '{8'h70, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[18] = '{8'h85, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        v[19] = '{8'h2A, 1'b0, 1'b0, 7'h00, 8'h00, 4'h9, 1'b1, 1'b0, 7'h00, 8'h00};
        v[20] = '{8'h85, 1'b0, 1'b0, 7'h00, 8'h00, 4'h6, 1'b1, 1'b0, 7'h00, 8'h00};
        v[21] = '{8'h30, 1'b0, 1'b0, 7'h00, 8'h00, 4'h9, 1'b1, 1'b0, 7'h00, 8'h00};
        v[22] = '{8'h27, 1'b0, 1'b0, 7'h00, 8'h00, 4'h6, 1'b1, 1'b0, 7'h00, 8'h00};
        v[23] = '{8'h70, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0, 1'b1, 1'b0, 7'h00, 8'h00};
        #1;
        chk("reset nib", 32'(rd_nibble), 32'h0);
        chk("reset ld_ready", 32'(ld_ready), 32'h1);
        chk("reset dw_valid", 32'(dw_valid), 32'h0);
        chk("reset overflow", 32'(dw_overflow), 32'h0);
        chk("reset rd_dev", 32'(rd_dev), 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;
        foreach (v[i]) begin
            bus_out = v[i].bus;
            ld_valid = v[i].ldv;
            ld_space = v[i].lsp;
            ld_addr = v[i].lad;
            ld_data = v[i].ldd;
            #1;
            chk($sformatf("v%0d nib", i), 32'(rd_nibble), 32'(v[i].nib));
            chk($sformatf("v%0d ld_ready", i), 32'(ld_ready), 32'(v[i].ldr));
            chk($sformatf("v%0d dw_valid", i), 32'(dw_valid), 32'(v[i].dwv));
            if (v[i].dwv) begin
                chk($sformatf("v%0d dw_addr", i), 32'(dw_addr), 32'(v[i].dwa));
                chk($sformatf("v%0d dw_data", i), 32'(dw_data), 32'(v[i].dwd));
            end
            tick();
        end
        ld_valid = 1'b0;
        dw_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            dev_write(8'(k), 1'b0);
            if (k == 4) chk("ovf after 4", 32'(dw_overflow), 32'h0);
        end
        chk("ovf after 5", 32'(dw_overflow), 32'h1);
        bus_out = 8'h70;
        for (int k = 1; k <= 4; k++) begin
            dw_ready = 1'b1;
            #1;
            chk($sformatf("drain%0d valid", k), 32'(dw_valid), 32'h1);
            chk($sformatf("drain%0d data", k), 32'(dw_data), 32'(k));
            chk($sformatf("drain%0d addr", k), 32'(dw_addr), 32'h05);
            tick();
        end
        chk("drained empty", 32'(dw_valid), 32'h0);
        dw_ready = 1'b0;
        for (int k = 1; k <= 4; k++) dev_write(8'(8'h10 + k), 1'b0);
        dev_write(8'h15, 1'b1);
        bus_out = 8'h70;
        for (int k = 2; k <= 5; k++) begin
            dw_ready = 1'b1;
            #1;
            chk($sformatf("fullpop%0d data", k), 32'(dw_data), 32'(8'h10 + k));
            tick();
        end
        chk("fullpop empty", 32'(dw_valid), 32'h0);
        step(8'h91);
        bus_out = 8'h1D;
        ld_valid = 1'b1;
        ld_space = 1'b1;
        ld_addr = 7'h20;
        ld_data = 8'h77;
        #1;
        chk("conflict ld_ready", 32'(ld_ready), 32'h0);
        tick();
        bus_out = 8'h70;
        #1;
        chk("retry ld_ready", 32'(ld_ready), 32'h1);
        tick();
        ld_valid = 1'b0;
        step(8'hA0);
        bus_out = 8'h70;
        #1;
        chk("load hi", 32'(rd_nibble), 32'h7);
        tick();
        chk("load lo", 32'(rd_nibble), 32'h7);
        step(8'h91);
        bus_out = 8'h30;
        #1;
        chk("bus wins hi", 32'(rd_nibble), 32'hD);
        tick();
        step(8'h91);
        step(8'h1C);
        bus_out = 8'h1F;
        #1;
        chk("pre-reset lo", 32'(rd_nibble), 32'h3);
        reset_n = 1'b0;
        #1;
        chk("mid reset nib", 32'(rd_nibble), 32'h0);
        chk("mid reset ld_ready", 32'(ld_ready), 32'h1);
        chk("mid reset overflow", 32'(dw_overflow), 32'h0);
        ld_valid = 1'b1;
        ld_space = 1'b1;
        ld_addr = 7'h21;
        ld_data = 8'h3C;
        tick();
        ld_valid = 1'b0;
        reset_n = 1'b1;
        step(8'h91);
        bus_out = 8'h30;
        #1;
        chk("retained hi", 32'(rd_nibble), 32'hC);
        tick();
        chk("retained lo", 32'(rd_nibble), 32'h3);
        step(8'hA1);
        bus_out = 8'h70;
        #1;
        chk("reset load hi", 32'(rd_nibble), 32'h3);
        tick();
        chk("reset load lo", 32'(rd_nibble), 32'hC);
        dev_in = 2'b10;
        #1;
        chk("sync 0", 32'(rd_dev), 32'h0);
        tick();
        chk("sync 1", 32'(rd_dev), 32'h0);
        tick();
        chk("sync 2", 32'(rd_dev), 32'h2);
        dev_in = 2'b01;
        tick();
        chk("sync 3", 32'(rd_dev), 32'h2);
        tick();
        chk("sync 4", 32'(rd_dev), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/moonbase_bus_responder.md
MOONBASE_BUS_RESPONDER -- requirements
Module: moonbase_bus_responder

Interface
REQ-001 Parameter BYTES_PER_SPACE, default 128: bytes in each of the code and data spaces; address width is 7 bits.
REQ-002 Parameter DW_FIFO_DEPTH, default 4: device-write FIFO entries, a power of two >= 2.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 bus_out  input  8  CPU io_out.
  - [7]=strobe; strobe=1 -> [6:0] is the address.
  - strobe=0 -> [6]=space (1 code, 0 data), [5]=ram write_n, [4]=device write_n, [3:0]=write nibble.
REQ-006 rd_nibble  output  4  memory read nibble; drives CPU io_in[5:2].
REQ-007 rd_dev  output  2  synchronized device input; drives CPU io_in[7:6].
REQ-008 dev_in  input  2  asynchronous external device read lines.
REQ-009 ld_valid, ld_space, ld_addr[6:0], ld_data[7:0]  input  loader byte write request.
REQ-010 ld_ready  output  1  loader write accepted this cycle when ld_valid=1.
REQ-011 dw_valid, dw_addr[6:0], dw_data[7:0]  output  head of the device-write FIFO.
REQ-012 dw_ready  input  1  sink pops the head when dw_valid=1.
REQ-013 dw_overflow  output  1  sticky flag: a device write was dropped.

Function
REQ-014 Memory SHALL be 2 x BYTES_PER_SPACE bytes, indexed by {space, latch}.
REQ-015 Address latch SHALL load bus_out[6:0] on every clock with strobe=1.
REQ-016 The nibble sequencer SHALL have four states: IDLE, HI, LO, DONE.
REQ-017 Sequencer transitions:
  - any state with strobe=1 -> HI;
  - HI with strobe=0 -> LO;
  - LO with strobe=0 -> DONE;
  - DONE with strobe=0 -> DONE.
REQ-018 rd_nibble SHALL be combinational, zero-latency:
  - HI -> mem[{bus_out[6],latch}][7:4];
  - LO -> the same byte's [3:0];
  - IDLE and DONE -> 0.
REQ-019 RAM write: strobe=0 and bus_out[5]=0 in HI or LO SHALL write bus_out[3:0] into the [7:4] (HI) or [3:0] (LO) nibble of mem[{bus_out[6],latch}] at the clock edge.
  - In IDLE and DONE the write is ignored.
REQ-020 Device write, high nibble: strobe=0 and bus_out[4]=0 in HI SHALL capture bus_out[3:0] into a hold register and set hold_valid.
REQ-021 Device write, low nibble: the same condition in LO with hold_valid=1 SHALL push {latch, hold, bus_out[3:0]} into the FIFO.
  - The push clears hold_valid.
  - A device write in LO without hold_valid, or in IDLE/DONE, is ignored.
REQ-022 strobe=1 SHALL clear hold_valid, so a half-written device byte is discarded.
REQ-023 FIFO ordering and handshake:
  - The FIFO SHALL be first-in first-out.
  - dw_valid SHALL be high when the FIFO is non-empty and SHALL be registered: a push becomes visible the next cycle.
  - A pop occurs when dw_valid and dw_ready are both high.
REQ-024 Push when full and no pop in the same cycle:
  - The entry is dropped and dw_overflow is set.
  - Push when full with a pop in the same cycle is accepted.
  - Push and pop when non-full both proceed; the count is unchanged.
REQ-025 dw_overflow SHALL clear only on reset.
REQ-026 ld_ready SHALL be 0 in any cycle with a RAM write per REQ-019, otherwise 1.
  - ld_valid with ld_ready=1 SHALL write ld_data to mem[{ld_space, ld_addr}] at the clock edge.
  - A bus write always wins over the loader.
REQ-027 rd_dev SHALL equal dev_in delayed through a two-flop synchronizer (2-cycle latency).
REQ-028 Pointer wrap-around: FIFO pointers wrap modulo DW_FIFO_DEPTH.

Reset
REQ-029 While reset_n=0, all of the following SHALL hold immediately, without waiting for a clock edge:
  - state IDLE, latch 0, hold_valid 0;
  - FIFO empty, dw_valid 0, dw_overflow 0;
  - synchronizer flops 0, rd_nibble 0, rd_dev 0, ld_ready 1.
REQ-030 Memory contents SHALL NOT be affected by reset.
  - A nibble written before reset asserts mid-write is retained.
  - While reset_n=0, bus writes are ignored and loader writes are accepted.

Verification
REQ-031 Code read:
  - Stimulus: loader writes code 0x03=0x5A; bus 0x83, then 0x7F, 0x7F, 0x7F.
  - Response: rd_nibble 0x5, 0xA, 0x0.
REQ-032 Data write and readback:
  - Stimulus: bus 0x91, then 0x1C, 0x13.
  - Response: data 0x11=0xC3; bus 0x91, 0x30, 0x30 gives rd_nibble 0xC, 0x3.
REQ-033 Device write:
  - Stimulus: bus 0x85, then 0x2A, 0x27.
  - Response: next cycle dw_valid=1, dw_addr=0x05, dw_data=0xA7.
REQ-034 Overflow:
  - Stimulus: dw_ready=0, five device writes with data 0x01..0x05.
  - Response: dw_overflow=1; raising dw_ready drains 0x01..0x04 in order, then dw_valid=0.
REQ-035 Conflict and abort:
  - Stimulus: ld_valid during bus write 0x1C.
  - Response: ld_ready=0 that cycle and the load completes next cycle.
  - Stimulus: bus 0x85, 0x2A, then 0x85.
  - Response: no FIFO push.
REQ-036 Reset mid-write:
  - Stimulus: reset_n=0 in LO after HI wrote 0xC.
  - Response: rd_nibble=0 at once; the 0xC nibble is retained in memory.
